// File: rtl/sc1_demux_sweep.sv
// Registered 1-to-NUM_CH demultiplexer with a sequenced clear-all sweep.
// Ports:
//   clk, rst (async, active-high)
//   enable, encoder_in, data_in, valid_in -> ready_out (valid/ready request side)
//   ch_bus (channel regs), ch_strobe (update pulses), busy (sweep), err_sel (sticky)
module sc1_demux_sweep #(
  parameter int WIDTH  = 4,
  parameter int SEL_W  = 4,
  parameter int NUM_CH = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [SEL_W-1:0]        encoder_in,
  input  logic [WIDTH-1:0]        data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [NUM_CH*WIDTH-1:0] ch_bus,
  output logic [NUM_CH-1:0]       ch_strobe,
  output logic                    busy,
  output logic                    err_sel
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [SEL_W-1:0] MAX_CODE = SEL_W'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CNT = SEL_W'(NUM_CH - 1);

  state_t                        state_q, state_d;
  logic [SEL_W-1:0]              cnt_q, cnt_d;
  logic [NUM_CH-1:0][WIDTH-1:0]  ch_q, ch_d;
  logic [NUM_CH-1:0]             stb_q, stb_d;
  logic                          err_q, err_d;
  logic                          accept;

  assign ready_out = enable & (state_q == IDLE);
  assign accept    = valid_in & ready_out;
  assign ch_bus    = ch_q;
  assign ch_strobe = stb_q;
  assign busy      = (state_q == CLEAR);
  assign err_sel   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    stb_d   = '0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (encoder_in == '0) begin
            state_d = CLEAR;
            cnt_d   = '0;
            err_d   = 1'b0;
          end else if (encoder_in > MAX_CODE) begin
            err_d = 1'b1;
          end else begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (encoder_in == SEL_W'(i + 1)) begin
                ch_d[i]  = data_in;
                stb_d[i] = 1'b1;
              end
            end
          end
        end
      end
      CLEAR: begin
        // Zero one channel per cycle, strobing it like a write.
        for (int i = 0; i < NUM_CH; i++) begin
          if (cnt_q == SEL_W'(i)) begin
            ch_d[i]  = '0;
            stb_d[i] = 1'b1;
          end
        end
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      stb_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      stb_q   <= stb_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/sc1_demux_sweep.md
Name: sc1_demux_sweep

Overview:
- Registered 1-to-NUM_CH demultiplexer; the write-side counterpart of the encoder-indexed output selector.
- Routes a WIDTH-bit word to the channel register addressed by encoder_in, using a valid/ready handshake.
- Code 0 launches a sequenced clear that zeroes each channel register in turn.
- Sits upstream of the selector and holds the per-channel values (i1..iN) that the selector later reads.

Parameters:
WIDTH, 4, data word width per channel
SEL_W, 4, width of encoder_in
NUM_CH, 11, number of channels; legal write codes are 1..NUM_CH; requires NUM_CH <= 2**SEL_W - 1

Ports:
clk  input  1  rising-edge clock (one clock)
rst  input  1  asynchronous, active-high reset
enable  input  1  global accept enable
encoder_in  input  SEL_W  channel code: 0 = clear-all, 1..NUM_CH = write channel, above NUM_CH = illegal
data_in  input  WIDTH  write data
valid_in  input  1  request valid
ready_out  output  1  request accepted when valid_in & ready_out
ch_bus  output  NUM_CH*WIDTH  channel registers, channel k (1-based) at bits [k*WIDTH-1 : (k-1)*WIDTH]
ch_strobe  output  NUM_CH  one-cycle update pulse per channel
busy  output  1  high while the clear sequence runs
err_sel  output  1  sticky illegal-code flag

Behaviour:
- Reset (async assert, sync release): all ch_bus 0, ch_strobe 0, busy 0, err_sel 0, state IDLE, sweep counter 0. Reset during CLEAR aborts the sweep; all registers read 0 immediately.
- States are IDLE and CLEAR.
- ready_out = enable & (state == IDLE), combinational. It is low throughout CLEAR regardless of enable.
- Accept = valid_in & ready_out. Nothing is captured on any other cycle. valid_in while ready_out is low is ignored, not queued.
- Accept with code k in 1..NUM_CH:
  - On the next edge, channel k is loaded with data_in.
  - ch_strobe[k-1] is 1 for exactly that one cycle.
  - Latency is 1 cycle. Back-to-back accepts are allowed every cycle.
  - Writing the same value still pulses the strobe.
- Accept with code 0:
  - Next state is CLEAR; busy=1 from the next cycle. The counter starts at 0.
  - In each CLEAR cycle c (0..NUM_CH-1), channel c+1 is zeroed on the edge ending that cycle, and ch_strobe[c] pulses on the following cycle.
  - After the cycle with c = NUM_CH-1, the block returns to IDLE. busy is high for exactly NUM_CH cycles.
  - err_sel is cleared when CLEAR is entered.
  - Data_in is ignored.
- Accept with code above NUM_CH: no register changes and no strobe; err_sel is set to 1 on the next edge and stays 1 until a clear command or reset.
- Deasserting enable during CLEAR does not pause or abort the sweep.
- ch_strobe is one-hot or zero at all times. It is never multi-hot because writes and the sweep are mutually exclusive.
- Untouched channels hold their values indefinitely.

Test Plan:
- Reset, then idle: ch_bus=0, ch_strobe=0, busy=0, err_sel=0, ready_out follows enable.
- enable=1, valid=1, code 3 with data 0xA, then code 11 with data 0x5 on consecutive cycles -> ch3=0xA with strobe[2] at cycle+1; ch11=0x5 with strobe[10] at cycle+2; other channels stay 0.
- Code 12, then code 15 -> no channel change, no strobe; err_sel=1 after the first and stays 1. Then a code-0 clear drops err_sel.
- All channels loaded with 0xF, then code 0 -> busy high 11 cycles; ready_out low; channels zero in order 1..11; strobes walk bit0..bit10. Valid requests issued during the sweep are dropped, and ready_out returns high on cycle 12.
- enable=0 with valid=1 and code 2 -> ready_out=0 and ch2 unchanged. enable dropped mid-sweep -> the sweep still completes in 11 cycles.
- Assert rst at sweep cycle 4 with channels 5..11 still 0xF -> all channels read 0 immediately; busy=0; after release, ready_out=1 on the first cycle.
